// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared state, op and fault encodings for the system command arbiter.
package bp_be_pkg;
  typedef enum logic [1:0] {e_ready, e_send, e_wait} bp_be_sys_arb_state_e;
  typedef enum logic [1:0] {e_src_dtlb, e_src_fault, e_src_pipe} bp_be_sys_arb_src_e;
  typedef enum logic [4:0] {
    e_csrrw, e_csrrs, e_csrrc, e_csrrwi, e_csrrsi, e_csrrci,
    e_dtlb_fill,
    e_op_instr_page_fault, e_op_load_page_fault, e_op_store_page_fault,
    e_op_load_misaligned, e_op_load_access_fault,
    e_op_store_misaligned, e_op_store_access_fault
  } bp_be_csr_fu_op_e;
  localparam int num_faults_lp = 7;
  localparam int fault_instr_pf_lp = 0;
  localparam int fault_load_pf_lp = 1;
  localparam int fault_store_pf_lp = 2;
  localparam int fault_load_misaligned_lp = 3;
  localparam int fault_load_access_lp = 4;
  localparam int fault_store_misaligned_lp = 5;
  localparam int fault_store_access_lp = 6;
  // Fault ops are laid out in fault-bit order starting at this base.
  localparam logic [4:0] fault_op_base_lp = e_op_instr_page_fault;
  function automatic logic [4:0] fault_op(input logic [num_faults_lp-1:0] oh);
    fault_op = fault_op_base_lp;
    for (int i = 0; i < num_faults_lp; i++)
      if (oh[i]) fault_op = fault_op_base_lp + 5'(i);
  endfunction
endpackage

// File: rtl/bsg_priority_encode.sv
// bsg_priority_encode: isolates the lowest set request bit as a one-hot grant.
module bsg_priority_encode #(
  parameter int width_p = 7
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o,
  output logic               v_o
);
  assign o = i & (~i + width_p'(1));
  assign v_o = |i;
endmodule

// File: rtl/bp_be_sys_cmd_arbiter.sv
// bp_be_sys_cmd_arbiter: buffers CSR/D-TLB/fault events and issues one command at a time by fixed priority.
module bp_be_sys_cmd_arbiter
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int dword_width_p = 64,
  parameter int csr_op_width_p = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      pipe_v_i,
  input  logic [csr_op_width_p-1:0] pipe_op_i,
  input  logic [11:0]               pipe_addr_i,
  input  logic [dword_width_p-1:0]  pipe_data_i,
  input  logic                      pipe_kill_i,
  output logic                      pipe_ready_o,
  input  logic                      dtlb_miss_v_i,
  input  logic [vaddr_width_p-1:0]  dtlb_miss_vaddr_i,
  output logic                      dtlb_ready_o,
  input  logic [6:0]                fault_v_i,
  input  logic                      flush_i,
  output logic                      csr_cmd_v_o,
  output logic [csr_op_width_p-1:0] csr_cmd_op_o,
  output logic [11:0]               csr_cmd_addr_o,
  output logic [dword_width_p-1:0]  csr_cmd_data_o,
  input  logic                      csr_cmd_ready_i,
  input  logic                      csr_resp_v_i,
  input  logic [dword_width_p-1:0]  csr_data_i,
  input  logic                      csr_exc_i,
  output logic                      resp_v_o,
  output logic [dword_width_p-1:0]  data_o,
  output logic                      exc_v_o
);
  bp_be_sys_arb_state_e state_q, state_n;
  bp_be_sys_arb_src_e src_q, src_n;
  logic pipe_v_q, dtlb_v_q, stale_q;
  logic [csr_op_width_p-1:0] pipe_op_q, win_op;
  logic [11:0] pipe_addr_q, win_addr;
  logic [dword_width_p-1:0] pipe_data_q, win_data;
  logic [vaddr_width_p-1:0] dtlb_vaddr_q;
  logic [num_faults_lp-1:0] fault_q, fault_oh, fault_win_q, fault_clr;
  logic fault_any, pending, pick, hs, pipe_cap, dtlb_cap;
  bsg_priority_encode #(.width_p(num_faults_lp)) fault_penc (
    .i(fault_q), .o(fault_oh), .v_o(fault_any)
  );
  assign pipe_ready_o = ~reset_i & ~pipe_v_q;
  assign dtlb_ready_o = ~reset_i & ~dtlb_v_q;
  assign pipe_cap = pipe_v_i & ~pipe_kill_i & pipe_ready_o & ~flush_i;
  assign dtlb_cap = dtlb_miss_v_i & dtlb_ready_o & ~flush_i;
  assign pending = dtlb_v_q | fault_any | pipe_v_q;
  // A flush discards everything unissued, so nothing may be picked in that cycle.
  assign pick = (state_q == e_ready) & pending & ~flush_i;
  assign hs = (state_q == e_send) & csr_cmd_ready_i;
  assign fault_clr = (hs && src_q == e_src_fault) ? fault_win_q : '0;
  assign src_n = dtlb_v_q ? e_src_dtlb : fault_any ? e_src_fault : e_src_pipe;
  assign win_op = dtlb_v_q ? csr_op_width_p'(e_dtlb_fill)
                : fault_any ? csr_op_width_p'(fault_op(fault_oh)) : pipe_op_q;
  assign win_addr = (dtlb_v_q | fault_any) ? '0 : pipe_addr_q;
  assign win_data = dtlb_v_q ? dword_width_p'(dtlb_vaddr_q) : fault_any ? '0 : pipe_data_q;
  always_comb begin
    state_n = (state_q == e_ready) ? (pick ? e_send : e_ready)
            : (state_q == e_send) ? (csr_cmd_ready_i ? e_wait : e_send)
            : (csr_resp_v_i ? e_ready : e_wait);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      pipe_v_q <= 1'b0;
      dtlb_v_q <= 1'b0;
      fault_q <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pipe_v_q <= ~flush_i & (pipe_cap | (pipe_v_q & ~(hs & src_q == e_src_pipe)));
      dtlb_v_q <= ~flush_i & (dtlb_cap | (dtlb_v_q & ~(hs & src_q == e_src_dtlb)));
      fault_q <= flush_i ? '0 : (fault_q & ~fault_clr) | fault_v_i;
      stale_q <= (state_n != e_ready) & (stale_q | flush_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (pipe_cap) begin
      pipe_op_q <= pipe_op_i;
      pipe_addr_q <= pipe_addr_i;
      pipe_data_q <= pipe_data_i;
    end
    if (dtlb_cap) dtlb_vaddr_q <= dtlb_miss_vaddr_i;
    if (pick) begin
      csr_cmd_op_o <= win_op;
      csr_cmd_addr_o <= win_addr;
      csr_cmd_data_o <= win_data;
      src_q <= src_n;
      fault_win_q <= fault_oh;
    end
  end
  assign csr_cmd_v_o = (state_q == e_send);
  assign resp_v_o = csr_resp_v_i & (state_q == e_wait) & ~stale_q;
  assign data_o = csr_data_i;
  assign exc_v_o = csr_exc_i & resp_v_o;
endmodule

// File: tb/tb_bp_be_sys_cmd_arbiter.sv
// tb_bp_be_sys_cmd_arbiter: table vectors, directed corner sequences and random traffic against an event-level model.
module tb_bp_be_sys_cmd_arbiter;
  import bp_be_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i, pipe_v_i, pipe_kill_i, pipe_ready_o, dtlb_miss_v_i, dtlb_ready_o, flush_i;
  logic [4:0] pipe_op_i, csr_cmd_op_o;
  logic [11:0] pipe_addr_i, csr_cmd_addr_o;
  logic [63:0] pipe_data_i, csr_cmd_data_o, csr_data_i, data_o;
  logic [38:0] dtlb_miss_vaddr_i;
  logic [6:0] fault_v_i;
  logic csr_cmd_v_o, csr_cmd_ready_i, csr_resp_v_i, csr_exc_i, resp_v_o, exc_v_o;
  bp_be_sys_cmd_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .pipe_v_i(pipe_v_i), .pipe_op_i(pipe_op_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
    .pipe_kill_i(pipe_kill_i), .pipe_ready_o(pipe_ready_o),
    .dtlb_miss_v_i(dtlb_miss_v_i), .dtlb_miss_vaddr_i(dtlb_miss_vaddr_i), .dtlb_ready_o(dtlb_ready_o),
    .fault_v_i(fault_v_i), .flush_i(flush_i),
    .csr_cmd_v_o(csr_cmd_v_o), .csr_cmd_op_o(csr_cmd_op_o), .csr_cmd_addr_o(csr_cmd_addr_o),
    .csr_cmd_data_o(csr_cmd_data_o), .csr_cmd_ready_i(csr_cmd_ready_i),
    .csr_resp_v_i(csr_resp_v_i), .csr_data_i(csr_data_i), .csr_exc_i(csr_exc_i),
    .resp_v_o(resp_v_o), .data_o(data_o), .exc_v_o(exc_v_o)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Event-level model: pending events, the command in flight and whether it went stale.
  logic m_pv = 0, m_dv = 0, m_stale = 0;
  logic [4:0] m_pop = 0;
  logic [11:0] m_paddr = 0;
  logic [63:0] m_pdata = 0;
  logic [38:0] m_daddr = 0;
  logic [6:0] m_f = 0;
  int m_ph = 0;
  int c_src = 0;
  logic [4:0] c_op = 0;
  logic [11:0] c_addr = 0;
  logic [63:0] c_data = 0;
  logic [4:0] issued[$];
  logic [4:0] fop[7];
  initial fop = '{e_op_instr_page_fault, e_op_load_page_fault, e_op_store_page_fault,
                  e_op_load_misaligned, e_op_load_access_fault, e_op_store_misaligned,
                  e_op_store_access_fault};
  function automatic int winner();
    if (m_dv) return -1;
    for (int i = 0; i < 7; i++) if (m_f[i]) return i;
    if (m_pv) return 7;
    return -2;
  endfunction
  task automatic idle();
    pipe_v_i = 0; pipe_op_i = 0; pipe_addr_i = 0; pipe_data_i = 0; pipe_kill_i = 0;
    dtlb_miss_v_i = 0; dtlb_miss_vaddr_i = 0; fault_v_i = 0; flush_i = 0;
    csr_cmd_ready_i = 0; csr_resp_v_i = 0; csr_data_i = 0; csr_exc_i = 0;
  endtask
  task automatic settle();
    logic er;
    #1;
    chk("pipe_ready", pipe_ready_o, !reset_i && !m_pv);
    chk("dtlb_ready", dtlb_ready_o, !reset_i && !m_dv);
    chk("cmd_v", csr_cmd_v_o, m_ph == 1);
    if (csr_cmd_v_o && m_ph == 1) begin
      chk("cmd_op", csr_cmd_op_o, c_op);
      chk("cmd_addr", csr_cmd_addr_o, c_addr);
      chk("cmd_data", csr_cmd_data_o, c_data);
    end
    er = csr_resp_v_i && m_ph == 2 && !m_stale;
    chk("resp_v", resp_v_o, er);
    chk("exc_v", exc_v_o, er && csr_exc_i);
    if (er) chk("resp_data", data_o, csr_data_i);
  endtask
  task automatic tick();
    int w;
    logic cp, cd, hs;
    if (reset_i) begin
      m_pv = 0; m_dv = 0; m_f = 0; m_ph = 0; m_stale = 0;
    end else begin
      cp = pipe_v_i && !pipe_kill_i && !m_pv;
      cd = dtlb_miss_v_i && !m_dv;
      hs = m_ph == 1 && csr_cmd_ready_i;
      w = winner();
      if (m_ph == 0) begin
        if (w != -2 && !flush_i) begin
          m_ph = 1; c_src = w;
          c_op = (w == -1) ? e_dtlb_fill : (w == 7) ? m_pop : fop[w];
          c_addr = (w == 7) ? m_paddr : 12'h0;
          c_data = (w == 7) ? m_pdata : (w == -1) ? {25'b0, m_daddr} : 64'h0;
        end
      end else if (m_ph == 1) begin
        if (hs) begin
          m_ph = 2;
          issued.push_back(c_op);
          if (c_src == -1) m_dv = 0;
          else if (c_src == 7) m_pv = 0;
          else m_f[c_src] = 0;
        end
      end else if (csr_resp_v_i) m_ph = 0;
      m_f |= fault_v_i;
      if (cp) begin m_pv = 1; m_pop = pipe_op_i; m_paddr = pipe_addr_i; m_pdata = pipe_data_i; end
      if (cd) begin m_dv = 1; m_daddr = dtlb_miss_vaddr_i; end
      if (flush_i) begin
        m_pv = 0; m_dv = 0; m_f = 0;
        if (m_ph != 0) m_stale = 1;
      end
      if (m_ph == 0) m_stale = 0;
    end
    @(negedge clk);
  endtask
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin settle(); tick(); end
  endtask
  task automatic drain(input int bound);
    idle();
    csr_cmd_ready_i = 1; csr_resp_v_i = 1; csr_data_i = 64'h77;
    for (int n = 0; n < bound; n++) begin
      if (!m_pv && !m_dv && m_f == 0 && m_ph == 0) begin idle(); return; end
      settle(); tick();
    end
    checks++; failures++;
    $display("FAIL drain_timeout: events still pending after %0d cycles", bound);
    idle();
  endtask
  typedef struct {
    logic pv; logic [4:0] op; logic [11:0] addr; logic [63:0] data;
    logic rdy, rv; logic [63:0] rdata;
    logic e_pr, e_cv; logic [4:0] e_op; logic [11:0] e_addr; logic [63:0] e_cdata;
    logic e_rv; logic [63:0] e_rdata;
  } vec_t;
  vec_t tbl[7];
  initial begin
    tbl[0] = '{1, e_csrrw, 12'h300, 64'hAB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, e_csrrw, 12'h300, 64'hAB, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, e_csrrw, 12'h300, 64'hAB, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 64'h5, 1, 0, 0, 0, 0, 1, 64'h5};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    idle();
    reset_i = 1;
    @(negedge clk);
    tick();
    settle();
    chk("rst_pipe_ready", pipe_ready_o, 0);
    chk("rst_dtlb_ready", dtlb_ready_o, 0);
    chk("rst_cmd_v", csr_cmd_v_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    tick();
    reset_i = 0;
    // Basic CSR round trip, cycle by cycle.
    for (int r = 0; r < 7; r++) begin
      idle();
      pipe_v_i = tbl[r].pv; pipe_op_i = tbl[r].op; pipe_addr_i = tbl[r].addr; pipe_data_i = tbl[r].data;
      csr_cmd_ready_i = tbl[r].rdy; csr_resp_v_i = tbl[r].rv; csr_data_i = tbl[r].rdata;
      settle();
      chk($sformatf("tbl%0d_pipe_ready", r), pipe_ready_o, tbl[r].e_pr);
      chk($sformatf("tbl%0d_cmd_v", r), csr_cmd_v_o, tbl[r].e_cv);
      if (tbl[r].e_cv) begin
        chk($sformatf("tbl%0d_cmd_op", r), csr_cmd_op_o, tbl[r].e_op);
        chk($sformatf("tbl%0d_cmd_addr", r), csr_cmd_addr_o, tbl[r].e_addr);
        chk($sformatf("tbl%0d_cmd_data", r), csr_cmd_data_o, tbl[r].e_cdata);
      end
      chk($sformatf("tbl%0d_resp_v", r), resp_v_o, tbl[r].e_rv);
      if (tbl[r].e_rv) chk($sformatf("tbl%0d_resp_data", r), data_o, tbl[r].e_rdata);
      tick();
    end
    // Simultaneous arrivals issue in priority order.
    issued.delete();
    idle();
    dtlb_miss_v_i = 1; dtlb_miss_vaddr_i = 39'h1000; fault_v_i = 7'b0000010;
    pipe_v_i = 1; pipe_op_i = e_csrrs; pipe_addr_i = 12'h305; pipe_data_i = 64'h7;
    cyc(1);
    drain(60);
    chk("order_count", issued.size(), 3);
    if (issued.size() >= 3) begin
      chk("order0", issued[0], e_dtlb_fill);
      chk("order1", issued[1], e_op_load_page_fault);
      chk("order2", issued[2], e_csrrs);
    end
    // Backpressure keeps the command stable and a full D-TLB slot drops new misses.
    issued.delete();
    idle();
    dtlb_miss_v_i = 1; dtlb_miss_vaddr_i = 39'h2222;
    cyc(1);
    idle();
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      dtlb_miss_v_i = (k == 2); dtlb_miss_vaddr_i = 39'h3333;
      settle();
      chk("stall_cmd_v", csr_cmd_v_o, 1);
      chk("stall_cmd_data", csr_cmd_data_o, 64'h2222);
      chk("stall_dtlb_ready", dtlb_ready_o, 0);
      tick();
    end
    drain(40);
    chk("stall_issue_count", issued.size(), 1);
    // Flush while waiting on a response: response suppressed, pending events discarded.
    idle();
    dtlb_miss_v_i = 1; dtlb_miss_vaddr_i = 39'h4000; fault_v_i = 7'b1000000;
    pipe_v_i = 1; pipe_op_i = e_csrrc; pipe_addr_i = 12'h340;
    cyc(1);
    idle();
    csr_cmd_ready_i = 1;
    cyc(1);
    settle();
    chk("flush_send", csr_cmd_v_o, 1);
    tick();
    csr_cmd_ready_i = 0; flush_i = 1;
    cyc(1);
    flush_i = 0; csr_resp_v_i = 1; csr_data_i = 64'h99;
    settle();
    chk("flush_resp_v", resp_v_o, 0);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("flush_no_cmd", csr_cmd_v_o, 0);
      tick();
    end
    // Killed pipe instruction is never captured.
    pipe_v_i = 1; pipe_kill_i = 1; pipe_op_i = e_csrrw;
    cyc(1);
    idle();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("kill_no_cmd", csr_cmd_v_o, 0);
      chk("kill_pipe_ready", pipe_ready_o, 1);
      tick();
    end
    // Reset during e_send drops the command and all pending events.
    pipe_v_i = 1; pipe_op_i = e_csrrwi; pipe_addr_i = 12'h100;
    cyc(1);
    idle();
    cyc(1);
    fault_v_i = 7'b0001000;
    settle();
    chk("rst_send_cmd_v", csr_cmd_v_o, 1);
    tick();
    idle();
    reset_i = 1;
    cyc(1);
    reset_i = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rst_after_cmd_v", csr_cmd_v_o, 0);
      chk("rst_after_pipe_ready", pipe_ready_o, 1);
      tick();
    end
    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      pipe_v_i = ($urandom % 3) == 0;
      pipe_op_i = 5'($urandom % 6);
      pipe_addr_i = 12'($urandom);
      pipe_data_i = {$urandom, $urandom};
      pipe_kill_i = ($urandom % 5) == 0;
      dtlb_miss_v_i = ($urandom % 4) == 0;
      dtlb_miss_vaddr_i = {7'($urandom), $urandom};
      fault_v_i = (($urandom % 6) == 0) ? 7'(1 << ($urandom % 7)) : 7'b0;
      flush_i = ($urandom % 40) == 0;
      csr_cmd_ready_i = 1'($urandom);
      csr_resp_v_i = ($urandom % 3) == 0;
      csr_data_i = {$urandom, $urandom};
      csr_exc_i = 1'($urandom);
      settle();
      tick();
    end
    drain(80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_be_sys_cmd_arbiter.md
# bp_be_sys_cmd_arbiter

Sequences all system-level events that target the CSR/exception unit: pipeline CSR instructions, D-TLB miss fills, and page/alignment/access faults. Events are buffered, one is chosen by fixed priority, and it is issued over a valid/ready port with at most one command outstanding. The block sits between the system pipe and memory/PTW fault sources on one side and the CSR unit on the other, replacing combinational same-cycle overriding with lossless, serialized issue.

## Interface
- vaddr_width_p, 39: virtual address width (D-TLB miss address).
- dword_width_p, 64: CSR data width.
- csr_op_width_p, 5: width of the CSR op encoding (bp_be_pkg fu_op).
- clk_i  in  1  clock; all state on posedge.
- reset_i  in  1  synchronous, active-high reset.
- pipe_v_i  in  1  CSR instruction from pipe.
- pipe_op_i / pipe_addr_i / pipe_data_i  in  csr_op_width_p / 12 / dword_width_p  op, CSR address, operand.
- pipe_kill_i  in  1  kills the pipe_v_i presented this cycle.
- pipe_ready_o  out  1  pipe slot empty.
- dtlb_miss_v_i  in  1  D-TLB miss fill request.
- dtlb_miss_vaddr_i  in  vaddr_width_p  missing address.
- dtlb_ready_o  out  1  D-TLB slot empty.
- fault_v_i  in  7  bit 0..6 = instr_pf, load_pf, store_pf, load_misaligned, load_access, store_misaligned, store_access.
- flush_i  in  1  discards all unissued events; marks outstanding command stale.
- csr_cmd_v_o  out  1  command valid.
- csr_cmd_op_o / csr_cmd_addr_o / csr_cmd_data_o  out  csr_op_width_p / 12 / dword_width_p.
- csr_cmd_ready_i  in  1  CSR unit accepts.
- csr_resp_v_i / csr_data_i / csr_exc_i  in  1 / dword_width_p / 1  CSR unit response.
- resp_v_o / data_o / exc_v_o  out  1 / dword_width_p / 1  response to writeback.

## Operation
- Slots: pipe slot (1 entry), D-TLB slot (1 entry), fault pending mask (7 sticky bits, OR-in, no backpressure).
- Capture: pipe_v_i & ~pipe_kill_i & pipe_ready_o loads pipe slot; dtlb_miss_v_i & dtlb_ready_o loads D-TLB slot; valid without ready is dropped (source's responsibility).
- Priority among registered pending: D-TLB > fault bit 0 > ... > fault bit 6 > pipe.
- Op mapping: D-TLB -> e_dtlb_fill, data = zero-extended vaddr; fault bit -> matching e_op_*_fault/misaligned, addr/data = 0; pipe -> fields as captured.
- FSM: e_ready (pick winner if any pending, latch into command regs, -> e_send); e_send (csr_cmd_v_o=1, fields stable; on csr_cmd_ready_i clear winner's slot/bit, -> e_wait); e_wait (on csr_resp_v_i -> e_ready).
- resp_v_o = csr_resp_v_i & in e_wait & ~stale; data_o = csr_data_i; exc_v_o = csr_exc_i & resp_v_o.
- flush_i: clears both slots and mask (same-cycle captures also discarded); in e_send/e_wait sets stale; command is not withdrawn. Stale clears on return to e_ready.

## Timing
- Reset: state e_ready, slots/mask/stale cleared; csr_cmd_v_o, resp_v_o, exc_v_o = 0; pipe_ready_o = dtlb_ready_o = 0 while reset_i high, 1 first cycle after.
- Event captured at cycle t is eligible at t+1; csr_cmd_v_o earliest t+2 (registered).
- Handshake at cycle h; csr_resp_v_i accepted h+1 or later; resp_v_o combinational same cycle; next csr_cmd_v_o earliest response+2.
- Fault bit set in the same cycle it is handshaked: new set wins, bit remains pending.
- Slot cleared on handshake and refilled same cycle: allowed; ready reflects pre-clear state (no same-cycle reuse).
- csr_resp_v_i outside e_wait: ignored.

## Structure
- bp_be_pkg: bp_be_sys_arb_state_e {e_ready, e_send, e_wait}; localparams for fault bit indices and fault-to-op mapping.
- Fault selection uses bsg_priority_encode (one-hot output); no other sub-module.

## Test plan
- Pipe csrrw addr 0x300 data 0xAB at t -> csr_cmd_v_o at t+2 with op csrrw, addr 0x300; resp data 0x5 -> resp_v_o, data_o=0x5.
- Same cycle: dtlb miss vaddr 0x1000, fault_v_i=7'b0000010, pipe cmd -> issue order e_dtlb_fill(0x1000), e_op_load_page_fault, pipe cmd.
- Hold csr_cmd_ready_i low 5 cycles -> csr_cmd_v_o and fields stable; second dtlb_miss_v_i dropped (dtlb_ready_o=0).
- flush_i in e_wait with pipe and fault pending -> response gives resp_v_o=0; nothing further issued.
- pipe_v_i with pipe_kill_i -> nothing captured, no command; reset_i asserted in e_send -> csr_cmd_v_o=0 next cycle, all pending cleared.
